// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package adder_pkg;

  localparam int ADDER_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder assembled from two half adders and an OR of their carries.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .A(A),
    .B(B),
    .S(s1),
    .C(c1)
  );

  half_adder u_ha1 (
    .A(s1),
    .B(Cin),
    .S(S),
    .C(c2)
  );

  // At most one half adder can produce a carry, so OR equals the true carry.
  assign Cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder; two of these plus an OR gate form the full-adder cell.
module half_adder (
  input  logic A,
  input  logic B,
  output logic S,
  output logic C
);

  assign S = A ^ B;
  assign C = A & B;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds A + B + Cin one bit per clock, LSB first, through one
// full-adder cell and a carry flip-flop, sequenced by a Start/Busy/Done handshake.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Only WIDTH-1 bits are kept; the final bit joins them straight into S.
  logic [WIDTH-2:0] sum_sr;
  logic [WIDTH-1:0] sum_next;
  logic [CW-1:0]    count;
  logic             carry;
  logic             msb_cin;
  logic             s_bit;
  logic             c_next;

  full_adder u_fa (
    .A(a_sr[0]),
    .B(b_sr[0]),
    .Cin(carry),
    .S(s_bit),
    .Cout(c_next)
  );

  assign sum_next = {s_bit, sum_sr};

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (count == CNT_LAST) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture, bit-serial datapath and result registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      count   <= '0;
      carry   <= 1'b0;
      msb_cin <= 1'b0;
      S       <= '0;
      Cout    <= 1'b0;
      V       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            a_sr   <= A;
            b_sr   <= B;
            carry  <= Cin;
            sum_sr <= '0;
            count  <= '0;
          end
        end
        ST_RUN: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          sum_sr <= sum_next[WIDTH-1:1];
          carry  <= c_next;
          count  <= count + CW'(1);
          // Carry out of bit WIDTH-2 is the carry into the MSB, needed for V.
          if (count == CNT_PEN) begin
            msb_cin <= c_next;
          end
          if (count == CNT_LAST) begin
            S    <= sum_next;
            Cout <= c_next;
            V    <= msb_cin ^ c_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Busy = (state == ST_RUN);
  assign Done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands on a
// WIDTH=8 instance and an exhaustive sweep on a WIDTH=2 instance.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8, v8;
  logic [7:0] a8, b8, s8;
  logic       start2, cin2, busy2, done2, cout2, v2;
  logic [1:0] a2, b2, s2;

  int errors;
  int checks;

  serial_adder #(.WIDTH(8)) dut8 (
    .CLK(clk), .Reset(rst), .Start(start8), .A(a8), .B(b8), .Cin(cin8),
    .Busy(busy8), .Done(done8), .S(s8), .Cout(cout8), .V(v8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .CLK(clk), .Reset(rst), .Start(start2), .A(a2), .B(b2), .Cin(cin2),
    .Busy(busy2), .Done(done2), .S(s2), .Cout(cout2), .V(v2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input logic cin,
                       output logic [31:0] s, output logic c, output logic v);
    longint m, ua, ub, tot, sa, sb, ss;
    m   = longint'(1) << w;
    ua  = longint'(a) & (m - 1);
    ub  = longint'(b) & (m - 1);
    tot = ua + ub + longint'(cin);
    s   = 32'(tot % m);
    c   = (tot >= m);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sb  = (ub >= m / 2) ? ub - m : ub;
    ss  = sa + sb + longint'(cin);
    v   = (ss >= m / 2) || (ss < -(m / 2));
  endtask

  task automatic drive(input int w, input logic st, input logic [31:0] a, input logic [31:0] b, input logic c);
    if (w == 8) begin
      start8 = st; a8 = a[7:0]; b8 = b[7:0]; cin8 = c;
    end else begin
      start2 = st; a2 = a[1:0]; b2 = b[1:0]; cin2 = c;
    end
  endtask

  function automatic logic obs_busy(input int w);
    return (w == 8) ? busy8 : busy2;
  endfunction

  function automatic logic obs_done(input int w);
    return (w == 8) ? done8 : done2;
  endfunction

  // Runs one operation and checks handshake timing; returns the result seen on Done.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input bit scramble, input bit hold,
                        output logic [31:0] s_o, output logic c_o, output logic v_o);
    int busy_n;
    int done_at;
    s_o = '0; c_o = 1'b0; v_o = 1'b0;
    @(negedge clk);
    drive(w, 1'b1, a, b, cin);
    busy_n  = 0;
    done_at = 0;
    for (int n = 1; n <= w + 4 && done_at == 0; n++) begin
      @(negedge clk);
      if (scramble) drive(w, hold, $urandom, $urandom, 1'($urandom_range(0, 1)));
      else          drive(w, hold, a, b, cin);
      if (obs_busy(w)) busy_n++;
      if (obs_done(w)) begin
        done_at = n;
        s_o = (w == 8) ? {24'h0, s8} : {30'h0, s2};
        c_o = (w == 8) ? cout8 : cout2;
        v_o = (w == 8) ? v8 : v2;
      end
    end
    check("done_latency", 64'(done_at), 64'(w + 1));
    check("busy_cycles", 64'(busy_n), 64'(w));
    @(negedge clk);
    check("done_single", 64'(obs_done(w)), 64'd0);
    check("busy_gap", 64'(obs_busy(w)), 64'd0);
  endtask

  task automatic check_result(input string tag, input logic [31:0] s, input logic c, input logic v,
                              input logic [31:0] es, input logic ec, input logic ev);
    check({tag, "_s"}, 64'(s), 64'(es));
    check({tag, "_cout"}, 64'(c), 64'(ec));
    check({tag, "_v"}, 64'(v), 64'(ev));
  endtask

  logic [31:0] rs, es, ra, rb;
  logic        rc, rv, ec, ev, rcin;
  int          cnt;

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    drive(8, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(2, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_s8", 64'(s8), 64'd0);
    check("rst_flags8", 64'({busy8, done8, cout8, v8}), 64'd0);
    check("rst_flags2", 64'({s2, busy2, done2, cout2, v2}), 64'd0);
    rst = 1'b0;

    // Directed cases with hand-computed results.
    run_op(8, 32'h00, 32'h00, 1'b0, 1'b0, 1'b0, rs, rc, rv);
    check_result("zero", rs, rc, rv, 32'h00, 1'b0, 1'b0);
    run_op(8, 32'hFF, 32'h01, 1'b0, 1'b0, 1'b0, rs, rc, rv);
    check_result("ff_01", rs, rc, rv, 32'h00, 1'b1, 1'b0);
    run_op(8, 32'h7F, 32'h01, 1'b0, 1'b0, 1'b0, rs, rc, rv);
    check_result("7f_01", rs, rc, rv, 32'h80, 1'b0, 1'b1);
    run_op(8, 32'h80, 32'h80, 1'b0, 1'b0, 1'b0, rs, rc, rv);
    check_result("80_80", rs, rc, rv, 32'h00, 1'b1, 1'b1);
    run_op(8, 32'h0F, 32'hF0, 1'b1, 1'b1, 1'b0, rs, rc, rv);
    check_result("0f_f0_scr", rs, rc, rv, 32'h00, 1'b1, 1'b0);

    // Start held high: one Done, an IDLE gap, then the next op starts.
    run_op(8, 32'h12, 32'h34, 1'b0, 1'b0, 1'b1, rs, rc, rv);
    check_result("hold", rs, rc, rv, 32'h46, 1'b0, 1'b0);
    @(negedge clk);
    check("hold_restart", 64'(busy8), 64'd1);
    start8 = 1'b0;
    cnt = 0;
    for (int n = 0; n < 12 && cnt == 0; n++) begin
      @(negedge clk);
      if (done8) begin
        cnt++;
        check("hold2_s", 64'(s8), 64'h46);
      end
    end
    check("hold2_done", 64'(cnt), 64'd1);
    repeat (2) @(negedge clk);

    // Reset in the fourth RUN cycle aborts the operation without a Done.
    drive(8, 1'b1, 32'hAA, 32'h55, 1'b0);
    cnt = 0;
    for (int n = 0; n < 12 && cnt < 4; n++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (busy8) cnt++;
    end
    check("abort_reached", 64'(cnt), 64'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outs", 64'({s8, cout8, v8, busy8, done8}), 64'd0);
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done8 || busy8) cnt++;
    end
    check("abort_no_done", 64'(cnt), 64'd0);
    run_op(8, 32'h01, 32'h02, 1'b0, 1'b0, 1'b0, rs, rc, rv);
    check_result("after_abort", rs, rc, rv, 32'h03, 1'b0, 1'b0);

    // Random operands against the reference model, with S hold check during idle.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rcin = 1'($urandom_range(0, 1));
      model(8, ra, rb, rcin, es, ec, ev);
      run_op(8, ra, rb, rcin, bit'($urandom_range(0, 1)), 1'b0, rs, rc, rv);
      check_result("rand8", rs, rc, rv, es, ec, ev);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("rand8_hold", 64'({cout8, v8, s8}), 64'({ec, ev, es[7:0]}));
    end

    // Exhaustive WIDTH=2 sweep.
    for (int i = 0; i < 32; i++) begin
      ra = 32'(i & 3);
      rb = 32'((i >> 2) & 3);
      rcin = 1'((i >> 4) & 1);
      model(2, ra, rb, rcin, es, ec, ev);
      run_op(2, ra, rb, rcin, 1'b1, 1'b0, rs, rc, rv);
      check_result("w2", rs, rc, rv, es, ec, ev);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
